// File: rtl/aes_inv_key_expander.sv
// Decryption-side AES-128 key scheduler: runs the key schedule backwards from the
// round-10 key, stores round keys 10..0 and serves them on a key_req/key_sel handshake.
module aes_inv_key_expander #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_WIDTH  = 128
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [3:0][KEY_WIDTH/32-1:0][7:0]  last_round_key,
    input  logic                               decrypt_en,
    input  logic                               key_req,
    input  logic [3:0]                         key_sel,
    output logic                               keys_valid,
    output logic                               key_rdy,
    output logic [3:0][KEY_WIDTH/32-1:0][7:0]  round_key
);

    localparam int unsigned NCOL  = KEY_WIDTH / 32;
    localparam int unsigned SLOTS = NUM_ROUNDS + 1;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [SLOTS] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [2:0] {IDLE, LOAD, COLS, SBOX_ST, COL0, DONE} state_e;

    state_e                      state_q, state_d;
    logic [3:0]                  rnd_q, rnd_m1;
    logic [3:0][7:0]             sub_q, sub_d;
    logic [3:0][NCOL-1:0][7:0]   store_q [SLOTS];
    logic                        key_rdy_q;
    logic [3:0][NCOL-1:0][7:0]   round_key_q;

    assign rnd_m1     = rnd_q - 4'd1;
    assign keys_valid = (state_q == DONE);
    assign key_rdy    = key_rdy_q;
    assign round_key  = round_key_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!decrypt_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = LOAD;
                LOAD:    state_d = COLS;
                COLS:    state_d = SBOX_ST;
                SBOX_ST: state_d = COL0;
                COL0:    state_d = (rnd_q == 4'd1) ? DONE : COLS;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // RotWord folded into the row index: output row r takes input row r+1.
    always_comb begin
        sub_d = '0;
        for (int unsigned r = 0; r < 4; r++)
            sub_d[r] = SBOX[store_q[rnd_m1][(r + 1) % 4][3]];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            store_q     <= '{default: '0};
            rnd_q       <= '0;
            sub_q       <= '0;
            key_rdy_q   <= 1'b0;
            round_key_q <= '0;
        end else begin
            key_rdy_q <= 1'b0;
            if (decrypt_en) begin
                unique case (state_q)
                    LOAD: begin
                        store_q[NUM_ROUNDS] <= last_round_key;
                        rnd_q               <= 4'(NUM_ROUNDS);
                    end
                    COLS: begin
                        for (int unsigned r = 0; r < 4; r++) begin
                            store_q[rnd_m1][r][3] <= store_q[rnd_q][r][3] ^ store_q[rnd_q][r][2];
                            store_q[rnd_m1][r][2] <= store_q[rnd_q][r][2] ^ store_q[rnd_q][r][1];
                            store_q[rnd_m1][r][1] <= store_q[rnd_q][r][1] ^ store_q[rnd_q][r][0];
                        end
                    end
                    SBOX_ST: sub_q <= sub_d;
                    COL0: begin
                        for (int unsigned r = 0; r < 4; r++)
                            store_q[rnd_m1][r][0] <= store_q[rnd_q][r][0] ^ sub_q[r]
                                                     ^ ((r == 0) ? RCON[rnd_q] : 8'h00);
                        rnd_q <= rnd_m1;
                    end
                    DONE: begin
                        if (key_req) begin
                            if (key_sel <= 4'(NUM_ROUNDS)) begin
                                key_rdy_q   <= 1'b1;
                                round_key_q <= store_q[key_sel];
                            end else begin
                                round_key_q <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_inv_key_expander.sv
// Self-checking bench for aes_inv_key_expander: word-level FIPS-style reverse key
// schedule model with a GF(2^8)-derived S-box, per-cycle compare plus directed vectors.
module tb_aes_inv_key_expander;

    typedef logic [3:0][3:0][7:0] mat_t;

    localparam logic [127:0] K10A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K0A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1A  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K10Z = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] Z1   = 128'h62636363626363636263636362636363;

    logic         clk = 1'b0;
    logic         resetn;
    logic [127:0] lrk_hex;
    mat_t         last_round_key;
    logic         decrypt_en;
    logic         key_req;
    logic [3:0]   key_sel;
    logic         keys_valid;
    logic         key_rdy;
    mat_t         round_key;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic mat_t to_mat(input logic [127:0] h);
        mat_t m;
        for (int k = 0; k < 16; k++) m[k % 4][k / 4] = h[127 - 8 * k -: 8];
        return m;
    endfunction

    function automatic logic [127:0] from_mat(input mat_t m);
        logic [127:0] h;
        for (int k = 0; k < 16; k++) h[127 - 8 * k -: 8] = m[k % 4][k / 4];
        return h;
    endfunction

    assign last_round_key = to_mat(lrk_hex);

    aes_inv_key_expander #(.NUM_ROUNDS(10), .KEY_WIDTH(128)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .last_round_key (last_round_key),
        .decrypt_en     (decrypt_en),
        .key_req        (key_req),
        .key_sel        (key_sel),
        .keys_valid     (keys_valid),
        .key_rdy        (key_rdy),
        .round_key      (round_key)
    );

    // ---------------- reference model ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = s;
        end
    end

    function automatic logic [127:0] model_key(input logic [127:0] k10, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int c = 0; c < 4; c++) w[40 + c] = k10[127 - 32 * c -: 32];
        for (int i = 43; i >= 4; i--) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                rc = 8'h01;
                for (int j = 1; j < i / 4; j++) rc = xtime(rc);
                t ^= {rc, 24'h0};
            end
            w[i - 4] = w[i] ^ t;
        end
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    // cnt = consecutive enabled edges; generation complete once 32 are seen.
    int           cnt;
    logic         rdy_exp;
    mat_t         rk_exp;
    logic [127:0] loaded;
    logic         kv_exp;

    assign kv_exp = (cnt >= 32);

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= 0;
            rdy_exp <= 1'b0;
            rk_exp  <= '0;
        end else begin
            rdy_exp <= 1'b0;
            if (cnt >= 32 && decrypt_en && key_req) begin
                if (key_sel <= 4'd10) begin
                    rdy_exp <= 1'b1;
                    rk_exp  <= to_mat(model_key(loaded, int'(key_sel)));
                end else begin
                    rk_exp <= '0;
                end
            end
            if (cnt == 1 && decrypt_en) loaded <= lrk_hex;
            cnt <= !decrypt_en ? 0 : (cnt < 32 ? cnt + 1 : cnt);
        end
    end

    always @(negedge clk) begin
        total++;
        if (keys_valid !== kv_exp || key_rdy !== rdy_exp || round_key !== rk_exp) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t: got kv=%b rdy=%b key=%h, expected kv=%b rdy=%b key=%h",
                     $time, keys_valid, key_rdy, from_mat(round_key), kv_exp, rdy_exp, from_mat(rk_exp));
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int n;
        int early;
        resetn = 1'b0; decrypt_en = 1'b0; key_req = 1'b1; key_sel = 4'd0; lrk_hex = K10A;
        repeat (3) step();
        chk("reset_kv", 128'(keys_valid), 128'd0);
        chk("reset_rdy", 128'(key_rdy), 128'd0);
        chk("reset_key", from_mat(round_key), 128'd0);
        chk("model_pin_k0", model_key(K10A, 0), K0A);
        chk("model_pin_k1", model_key(K10A, 1), K1A);
        chk("model_pin_z1", model_key(K10Z, 1), Z1);
        resetn = 1'b1; key_req = 1'b0;
        step();

        // generation latency and first key
        decrypt_en = 1'b1;
        step();
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            step();
            if (keys_valid) n = i;
        end
        chk("latency", 128'(n), 128'd31);
        key_sel = 4'd0; key_req = 1'b1;
        step();
        chk("k0_rdy", 128'(key_rdy), 128'd1);
        chk("k0", from_mat(round_key), K0A);

        // back-to-back 10..1
        for (int s = 10; s >= 1; s--) begin
            key_sel = 4'(s);
            step();
            chk("b2b_rdy", 128'(key_rdy), 128'd1);
            if (s == 10)     chk("k10", from_mat(round_key), K10A);
            else if (s == 1) chk("k1", from_mat(round_key), K1A);
            else             chk("kmid", from_mat(round_key), model_key(K10A, s));
        end

        // invalid selects
        key_sel = 4'd11; step();
        chk("sel11_rdy", 128'(key_rdy), 128'd0);
        chk("sel11_key", from_mat(round_key), 128'd0);
        key_sel = 4'd15; step();
        chk("sel15_rdy", 128'(key_rdy), 128'd0);
        chk("sel15_key", from_mat(round_key), 128'd0);

        // hold when no request
        key_sel = 4'd5; step();
        chk("k5", from_mat(round_key), model_key(K10A, 5));
        key_req = 1'b0; key_sel = 4'd2;
        repeat (2) step();
        chk("hold_rdy", 128'(key_rdy), 128'd0);
        chk("hold_key", from_mat(round_key), model_key(K10A, 5));

        // new last_round_key ignored while enable stays high
        lrk_hex = K10Z; key_req = 1'b1; key_sel = 4'd10; step();
        chk("no_regen", from_mat(round_key), K10A);

        // drop enable in DONE
        key_req = 1'b0; decrypt_en = 1'b0; step();
        chk("drop_done_kv", 128'(keys_valid), 128'd0);

        // abort at cycle 15 of generation
        lrk_hex = K10A; decrypt_en = 1'b1;
        repeat (15) step();
        decrypt_en = 1'b0; step();
        chk("abort_kv", 128'(keys_valid), 128'd0);

        // regenerate from zero-key schedule with a request held throughout
        lrk_hex = K10Z; decrypt_en = 1'b1; key_req = 1'b1; key_sel = 4'd3;
        step();
        n = 0; early = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            step();
            if (keys_valid) n = i;
            else if (key_rdy) early++;
        end
        chk("latency2", 128'(n), 128'd31);
        chk("rdy_before_done", 128'(early), 128'd0);
        chk("rdy_at_done", 128'(key_rdy), 128'd0);
        step();
        chk("z3_rdy", 128'(key_rdy), 128'd1);
        chk("z3", from_mat(round_key), model_key(K10Z, 3));
        key_sel = 4'd0; step();
        chk("z0_rdy", 128'(key_rdy), 128'd1);
        chk("z0", from_mat(round_key), 128'd0);
        key_sel = 4'd1; step();
        chk("z1", from_mat(round_key), Z1);

        // asynchronous reset mid-generation
        decrypt_en = 1'b0; step();
        decrypt_en = 1'b1;
        repeat (10) step();
        resetn = 1'b0;
        #1;
        chk("areset_kv", 128'(keys_valid), 128'd0);
        chk("areset_rdy", 128'(key_rdy), 128'd0);
        chk("areset_key", from_mat(round_key), 128'd0);
        step();
        resetn = 1'b1;
        step();
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            step();
            if (keys_valid) n = i;
        end
        chk("latency3", 128'(n), 128'd31);
        key_sel = 4'd1; step();
        chk("z1_after_reset", from_mat(round_key), Z1);

        key_req = 1'b0; decrypt_en = 1'b0;
        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
